// File: rtl/rhs_stim_sequencer.sv
// rhs_stim_sequencer: biphasic stimulation pulse-train sequencer timed by SPI sample ticks.
// Define RHS_STIM_RAMP_EN to add cfg_ramp_step and a per-train saturating magnitude ramp.
module rhs_stim_sequencer #(
    parameter int NUM_PROBES = 16,
    parameter int CNT_W = 16,
    parameter int MAG_W = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sample_tick,
    input  logic [CNT_W-1:0]      cfg_pulse_length,
    input  logic [CNT_W-1:0]      cfg_inter_pulse_delay,
    input  logic [CNT_W-1:0]      cfg_inter_bipulse_delay,
    input  logic [CNT_W-1:0]      cfg_inter_train_delay,
    input  logic [CNT_W-1:0]      cfg_charge_recovery_time,
    input  logic [CNT_W-1:0]      cfg_bipulses_per_train,
    input  logic [CNT_W-1:0]      cfg_train_count,
    input  logic [MAG_W-1:0]      cfg_magnitude,
`ifdef RHS_STIM_RAMP_EN
    input  logic [MAG_W-1:0]      cfg_ramp_step,
`endif
    input  logic                  cfg_rising_edge_first,
    input  logic                  cfg_bipolar_mode,
    input  logic [NUM_PROBES-1:0] cfg_mask_pos,
    input  logic [NUM_PROBES-1:0] cfg_mask_neg,
    input  logic                  finite_start,
    input  logic                  infinite_start,
    input  logic                  infinite_stop,
    output logic                  stim_on,
    output logic                  stim_pol,
    output logic [NUM_PROBES-1:0] stim_mask_pos,
    output logic [NUM_PROBES-1:0] stim_mask_neg,
    output logic [MAG_W-1:0]      stim_magnitude,
    output logic                  charge_recovery,
    output logic                  busy,
    output logic [CNT_W-1:0]      train_index,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, ARMED, PHASE1, IPD, PHASE2, IBD, RECOVERY, ITD} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] r_pulse, r_ipd, r_ibd, r_itd, r_rec, r_bp, r_tr;
    logic [CNT_W-1:0] rem, rem_nx, bp_cnt, bp_nx, idx_nx, pulse_len;
    logic [MAG_W-1:0] r_mag, mag_lvl;
    logic [NUM_PROBES-1:0] r_mpos, r_mneg;
    logic r_rise, r_bip, inf_mode, stop_pending, stop_now, done_nx;
    logic accept, zero_run, exit_now, last_bp, more_tr, p2_exit, rec_entry, rec_exit;
    logic go_p1, go_p2, ipd_entry, ibd_entry, itd_entry, go_idle, on_nx;

`ifdef RHS_STIM_RAMP_EN
    localparam int RW = MAG_W + CNT_W + 1;
    logic [MAG_W-1:0] r_step;
    logic [RW-1:0] ramp;
    always_comb begin
        ramp = RW'(r_mag) + RW'(idx_nx) * RW'(r_step);
        mag_lvl = (|ramp[RW-1:MAG_W]) ? '1 : ramp[MAG_W-1:0];
    end
`else
    assign mag_lvl = r_mag;
`endif

    always_comb begin
        accept    = (state == IDLE) && (finite_start || infinite_start);
        zero_run  = (cfg_bipulses_per_train == '0) || (!infinite_start && cfg_train_count == '0);
        pulse_len = (r_pulse == '0) ? CNT_W'(1) : r_pulse;
        stop_now  = stop_pending || infinite_stop;
        exit_now  = sample_tick && (state inside {PHASE1, IPD, PHASE2, IBD, RECOVERY, ITD})
                    && rem <= CNT_W'(1);
        last_bp   = bp_cnt == r_bp - CNT_W'(1);
        more_tr   = !stop_now && (inf_mode || train_index != r_tr - CNT_W'(1));
        // Zero-length gaps fall straight through to their successor on the same tick.
        ipd_entry = state == PHASE1 && exit_now && r_ipd != '0;
        go_p2     = (state == IPD && exit_now) || (state == PHASE1 && exit_now && r_ipd == '0);
        p2_exit   = state == PHASE2 && exit_now;
        ibd_entry = p2_exit && !last_bp && r_ibd != '0;
        rec_entry = p2_exit && last_bp;
        rec_exit  = (state == RECOVERY && exit_now) || (rec_entry && r_rec == '0);
        itd_entry = rec_exit && more_tr && r_itd != '0;
        go_idle   = rec_exit && !more_tr;
        go_p1     = (state == ARMED && sample_tick) || (state inside {IBD, ITD} && exit_now)
                    || (p2_exit && !last_bp && r_ibd == '0) || (rec_exit && more_tr && r_itd == '0);
        state_nx  = state;
        rem_nx    = (sample_tick && rem > CNT_W'(1)) ? rem - CNT_W'(1) : rem;
        bp_nx     = p2_exit ? (last_bp ? '0 : bp_cnt + CNT_W'(1)) : bp_cnt;
        idx_nx    = (rec_exit && more_tr && !(&train_index)) ? train_index + CNT_W'(1) : train_index;
        done_nx   = go_idle;
        if (go_p1) begin
            state_nx = PHASE1;
            rem_nx   = pulse_len;
        end
        if (ipd_entry) begin
            state_nx = IPD;
            rem_nx   = r_ipd;
        end
        if (go_p2) begin
            state_nx = PHASE2;
            rem_nx   = pulse_len;
        end
        if (ibd_entry) begin
            state_nx = IBD;
            rem_nx   = r_ibd;
        end
        if (rec_entry && r_rec != '0) begin
            state_nx = RECOVERY;
            rem_nx   = r_rec;
        end
        if (itd_entry) begin
            state_nx = ITD;
            rem_nx   = r_itd;
        end
        if (go_idle) state_nx = IDLE;
        if (accept) begin
            state_nx = zero_run ? IDLE : ARMED;
            done_nx  = zero_run;
            idx_nx   = '0;
            bp_nx    = '0;
        end
        on_nx = state_nx inside {PHASE1, PHASE2};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            {rem, bp_cnt, train_index, done, stop_pending, inf_mode} <= '0;
            {r_pulse, r_ipd, r_ibd, r_itd, r_rec, r_bp, r_tr} <= '0;
            {r_mag, r_mpos, r_mneg, r_rise, r_bip} <= '0;
            {stim_on, stim_pol, stim_mask_pos, stim_mask_neg, stim_magnitude} <= '0;
            {charge_recovery, busy} <= '0;
`ifdef RHS_STIM_RAMP_EN
            r_step <= '0;
`endif
        end else begin
            state           <= state_nx;
            rem             <= rem_nx;
            bp_cnt          <= bp_nx;
            train_index     <= idx_nx;
            done            <= done_nx;
            stop_pending    <= (state != IDLE) && stop_now;
            stim_on         <= on_nx;
            stim_pol        <= on_nx && ((state_nx == PHASE1) ? r_rise : !r_rise);
            stim_mask_pos   <= on_nx ? r_mpos : '0;
            stim_mask_neg   <= (on_nx && r_bip) ? r_mneg : '0;
            stim_magnitude  <= on_nx ? mag_lvl : '0;
            charge_recovery <= state_nx == RECOVERY;
            busy            <= state_nx != IDLE;
            if (accept) begin
                inf_mode <= infinite_start;
                r_pulse  <= cfg_pulse_length;
                r_ipd    <= cfg_inter_pulse_delay;
                r_ibd    <= cfg_inter_bipulse_delay;
                r_itd    <= cfg_inter_train_delay;
                r_rec    <= cfg_charge_recovery_time;
                r_bp     <= cfg_bipulses_per_train;
                r_tr     <= cfg_train_count;
                r_mag    <= cfg_magnitude;
                r_rise   <= cfg_rising_edge_first;
                r_bip    <= cfg_bipolar_mode;
                r_mpos   <= cfg_mask_pos;
                r_mneg   <= cfg_mask_neg;
`ifdef RHS_STIM_RAMP_EN
                r_step   <= cfg_ramp_step;
`endif
            end
        end
    end
endmodule

// File: tb/tb_rhs_stim_sequencer.sv
// tb_rhs_stim_sequencer: directed vector table of whole runs plus hand-written corner sequences.
module tb_rhs_stim_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, sample_tick, finite_start, infinite_start, infinite_stop;
    logic [15:0] cfg_pulse_length, cfg_inter_pulse_delay, cfg_inter_bipulse_delay;
    logic [15:0] cfg_inter_train_delay, cfg_charge_recovery_time, cfg_bipulses_per_train, cfg_train_count;
    logic [7:0] cfg_magnitude, cfg_ramp_step;
    logic cfg_rising_edge_first, cfg_bipolar_mode;
    logic [15:0] cfg_mask_pos, cfg_mask_neg;
    logic stim_on, stim_pol, charge_recovery, busy, done;
    logic [15:0] stim_mask_pos, stim_mask_neg, train_index;
    logic [7:0] stim_magnitude;

    rhs_stim_sequencer dut (
        .clk(clk), .rstn(rstn), .sample_tick(sample_tick),
        .cfg_pulse_length(cfg_pulse_length), .cfg_inter_pulse_delay(cfg_inter_pulse_delay),
        .cfg_inter_bipulse_delay(cfg_inter_bipulse_delay), .cfg_inter_train_delay(cfg_inter_train_delay),
        .cfg_charge_recovery_time(cfg_charge_recovery_time), .cfg_bipulses_per_train(cfg_bipulses_per_train),
        .cfg_train_count(cfg_train_count), .cfg_magnitude(cfg_magnitude),
`ifdef RHS_STIM_RAMP_EN
        .cfg_ramp_step(cfg_ramp_step),
`endif
        .cfg_rising_edge_first(cfg_rising_edge_first), .cfg_bipolar_mode(cfg_bipolar_mode),
        .cfg_mask_pos(cfg_mask_pos), .cfg_mask_neg(cfg_mask_neg),
        .finite_start(finite_start), .infinite_start(infinite_start), .infinite_stop(infinite_stop),
        .stim_on(stim_on), .stim_pol(stim_pol), .stim_mask_pos(stim_mask_pos), .stim_mask_neg(stim_mask_neg),
        .stim_magnitude(stim_magnitude), .charge_recovery(charge_recovery), .busy(busy),
        .train_index(train_index), .done(done)
    );

    int tests = 0, fails = 0;

    typedef struct {
        int p, ipd, ibd, itd, rec, bp, tr;
        int exp_ticks, exp_on, exp_idx;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic set_cfg(input int p, ipd, ibd, itd, rec, bp, tr);
        cfg_pulse_length         = 16'(p);
        cfg_inter_pulse_delay    = 16'(ipd);
        cfg_inter_bipulse_delay  = 16'(ibd);
        cfg_inter_train_delay    = 16'(itd);
        cfg_charge_recovery_time = 16'(rec);
        cfg_bipulses_per_train   = 16'(bp);
        cfg_train_count          = 16'(tr);
    endtask

    task automatic start(input logic fin, input logic inf);
        finite_start = fin;
        infinite_start = inf;
        @(negedge clk);
        finite_start = 1'b0;
        infinite_start = 1'b0;
    endtask

    task automatic tick1();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Ticks every 4 clk until done; n counts ticks including the one that raised done (-1 on timeout).
    task automatic run(input int max_ticks, output int n, output int on_cnt, output int rec_cnt,
                       output logic pulse_ok);
        n = 0; on_cnt = 0; rec_cnt = 0; pulse_ok = 1'b0;
        for (int i = 0; i < max_ticks; i++) begin
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
            n++;
            if (done) begin
                @(negedge clk);
                pulse_ok = !done;
                repeat (2) @(negedge clk);
                return;
            end
            on_cnt += int'(stim_on);
            rec_cnt += int'(charge_recovery);
            repeat (3) @(negedge clk);
        end
        n = -1;
    endtask

    int n, on_cnt, rec_cnt;
    logic pulse_ok, found;
    int exp_mag[4];

    initial begin
        vecs[0] = '{3, 3, 3, 11, 8, 4, 4, 245, 96, 3};
        vecs[1] = '{2, 0, 0, 0, 0, 2, 1, 8, 8, 0};
        vecs[2] = '{0, 1, 0, 2, 1, 3, 2, 22, 12, 1};
        vecs[3] = '{1, 0, 2, 0, 3, 1, 3, 15, 6, 2};
        vecs[4] = '{2, 1, 1, 1, 0, 2, 2, 23, 16, 1};
        rstn = 1'b0; sample_tick = 1'b0; finite_start = 1'b0; infinite_start = 1'b0; infinite_stop = 1'b0;
        set_cfg(3, 3, 3, 11, 8, 4, 4);
        cfg_magnitude = 8'd100; cfg_ramp_step = 8'd0;
        cfg_rising_edge_first = 1'b1; cfg_bipolar_mode = 1'b1;
        cfg_mask_pos = 16'h0080; cfg_mask_neg = 16'h8000;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {stim_on, stim_pol, stim_mask_pos, stim_mask_neg, stim_magnitude,
            charge_recovery, busy, train_index, done}, 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            set_cfg(vecs[v].p, vecs[v].ipd, vecs[v].ibd, vecs[v].itd, vecs[v].rec, vecs[v].bp, vecs[v].tr);
            start(1'b1, 1'b0);
            run(400, n, on_cnt, rec_cnt, pulse_ok);
            chk($sformatf("vec%0d_ticks_to_done", v), n - 1, vecs[v].exp_ticks);
            chk($sformatf("vec%0d_stim_on_ticks", v), on_cnt, vecs[v].exp_on);
            chk($sformatf("vec%0d_train_index", v), train_index, vecs[v].exp_idx);
            chk($sformatf("vec%0d_done_one_clk", v), pulse_ok, 1);
            chk($sformatf("vec%0d_idle_after", v), busy, 0);
        end

        // Bipolar, rising-first run: outputs per phase and cfg changes ignored mid-run
        set_cfg(3, 3, 3, 11, 8, 4, 4);
        start(1'b1, 1'b0);
        chk("armed_busy", busy, 1);
        tick1();
        chk("p1_on_pol", {stim_on, stim_pol}, 2'b11);
        chk("p1_mask_pos", stim_mask_pos, 16'h0080);
        chk("p1_mask_neg", stim_mask_neg, 16'h8000);
        chk("p1_mag", stim_magnitude, 100);
        cfg_mask_pos = 16'hFFFF; cfg_magnitude = 8'd7; cfg_rising_edge_first = 1'b0;
        repeat (3) tick1();
        chk("ipd_outputs_zero", {stim_on, stim_pol, stim_mask_pos, stim_mask_neg, stim_magnitude}, 0);
        repeat (3) tick1();
        chk("p2_on_pol", {stim_on, stim_pol}, 2'b10);
        chk("p2_latched_mask", stim_mask_pos, 16'h0080);
        chk("p2_latched_mag", stim_magnitude, 100);
        repeat (39) tick1();
        chk("recovery_state", {charge_recovery, stim_on, busy}, 3'b101);
        run(400, n, on_cnt, rec_cnt, pulse_ok);
        chk("rest_of_run_ticks", n, 200);
        chk("rest_of_run_index", train_index, 3);
        cfg_mask_pos = 16'h0F0F; cfg_mask_neg = 16'hF0F0; cfg_magnitude = 8'd100;

        // Monopolar, falling-first
        cfg_bipolar_mode = 1'b0;
        set_cfg(1, 0, 0, 0, 0, 1, 1);
        start(1'b1, 1'b0);
        tick1();
        chk("mono_p1", {stim_on, stim_pol, stim_mask_pos, stim_mask_neg}, {2'b10, 16'h0F0F, 16'h0000});
        tick1();
        chk("mono_p2", {stim_on, stim_pol, stim_mask_pos, stim_mask_neg}, {2'b11, 16'h0F0F, 16'h0000});
        run(10, n, on_cnt, rec_cnt, pulse_ok);
        chk("mono_done_ticks", n, 1);
        cfg_bipolar_mode = 1'b1; cfg_rising_edge_first = 1'b1;

        // Infinite run stopped during PHASE2 of train 2; a simultaneous finite start is ignored
        set_cfg(1, 1, 1, 1, 2, 2, 0);
        start(1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick1();
            found = train_index == 16'd2 && stim_on && !stim_pol;
        end
        chk("inf_reached_train2_p2", found, 1);
        chk("inf_index_at_stop", train_index, 2);
        infinite_stop = 1'b1; finite_start = 1'b1;
        @(negedge clk);
        infinite_stop = 1'b0; finite_start = 1'b0;
        chk("inf_busy_after_stop", busy, 1);
        run(100, n, on_cnt, rec_cnt, pulse_ok);
        chk("stop_ticks_to_done", n, 7);
        chk("stop_stim_on_ticks", on_cnt, 2);
        chk("stop_recovery_ticks", rec_cnt, 2);
        chk("stop_index_final", train_index, 2);
        chk("stop_done_one_clk", pulse_ok, 1);

        // Stop with start while idle: stop is dropped, both trains run
        set_cfg(1, 0, 0, 0, 0, 1, 2);
        infinite_stop = 1'b1; finite_start = 1'b1;
        @(negedge clk);
        infinite_stop = 1'b0; finite_start = 1'b0;
        run(20, n, on_cnt, rec_cnt, pulse_ok);
        chk("idle_stop_ticks", n, 5);
        chk("idle_stop_index", train_index, 1);

        // Degenerate finite runs finish without stimulating
        set_cfg(1, 0, 0, 0, 0, 0, 3);
        start(1'b1, 1'b0);
        chk("zero_bp_done", {done, busy, stim_on}, 3'b100);
        @(negedge clk);
        chk("zero_bp_done_drop", done, 0);
        set_cfg(1, 0, 0, 0, 0, 2, 0);
        start(1'b1, 1'b0);
        chk("zero_tr_done", {done, busy, stim_on}, 3'b100);

        // Asynchronous reset during PHASE1
        set_cfg(3, 3, 3, 11, 8, 4, 4);
        start(1'b1, 1'b0);
        tick1();
        chk("pre_reset_on", stim_on, 1);
        #2 rstn = 1'b0;
        #1 chk("async_reset_outputs", {stim_on, stim_pol, stim_mask_pos, stim_mask_neg, stim_magnitude,
            charge_recovery, busy, train_index, done}, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        set_cfg(2, 0, 0, 0, 0, 2, 1);
        start(1'b1, 1'b0);
        tick1();
        tick1();
        cfg_pulse_length = 16'd7;
        start(1'b1, 1'b1);
        chk("busy_start_busy", busy, 1);
        chk("busy_start_index", train_index, 0);
        run(50, n, on_cnt, rec_cnt, pulse_ok);
        chk("busy_start_ignored_ticks", n, 7);
        chk("busy_start_on_ticks", on_cnt, 6);

        // Per-train magnitude (ramped and saturated when the ramp is built in)
`ifdef RHS_STIM_RAMP_EN
        exp_mag = '{250, 253, 255, 255};
`else
        exp_mag = '{250, 250, 250, 250};
`endif
        set_cfg(1, 0, 0, 0, 0, 1, 4);
        cfg_magnitude = 8'd250; cfg_ramp_step = 8'd3;
        start(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick1();
            chk($sformatf("mag_train%0d_p1", k), stim_magnitude, exp_mag[k]);
            tick1();
            chk($sformatf("mag_train%0d_p2", k), stim_magnitude, exp_mag[k]);
        end
        run(10, n, on_cnt, rec_cnt, pulse_ok);
        chk("mag_run_done", n, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
